// File: rtl/muldiv_unit.sv
// muldiv_unit: single-cycle MULT/MULTU and a 32-iteration restoring divider with a stall request
module muldiv_unit #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [1:0]     op_i,
    input  logic [W-1:0]   opdata1_i,
    input  logic [W-1:0]   opdata2_i,
    input  logic           annul_i,
    output logic           stallreq_o,
    output logic           busy_o,
    output logic           ready_o,
    output logic [2*W-1:0] result_o
);
    typedef enum logic [1:0] {IDLE, DIVON, DIVZERO, END} state_t;
    state_t         state;
    logic [2*W:0]   dvd;
    logic [W-1:0]   dvs;
    logic [5:0]     cnt;
    logic           neg_q, neg_r;
    logic           sdiv;
    logic [W-1:0]   a_abs, b_abs, q_fix, r_fix;
    logic [2*W-1:0] mul_a, mul_b, prod;
    logic [W:0]     diff;

    always_comb begin
        sdiv  = op_i == 2'b10;
        a_abs = (sdiv && opdata1_i[W-1]) ? -opdata1_i : opdata1_i;
        b_abs = (sdiv && opdata2_i[W-1]) ? -opdata2_i : opdata2_i;
        mul_a = op_i[0] ? {{W{1'b0}}, opdata1_i} : {{W{opdata1_i[W-1]}}, opdata1_i};
        mul_b = op_i[0] ? {{W{1'b0}}, opdata2_i} : {{W{opdata2_i[W-1]}}, opdata2_i};
        prod  = mul_a * mul_b;
        diff  = dvd[2*W:W] - {1'b0, dvs};
        q_fix = neg_q ? -dvd[W-1:0] : dvd[W-1:0];
        r_fix = neg_r ? -dvd[2*W:W+1] : dvd[2*W:W+1];
        busy_o     = state != IDLE;
        stallreq_o = (state == IDLE && start_i && !annul_i) || state == DIVON || state == DIVZERO;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i && !op_i[1]) begin
                        result_o <= prod;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end else if (start_i && opdata2_i == '0) begin
                        state <= DIVZERO;
                    end else if (start_i) begin
                        dvd   <= {{W{1'b0}}, a_abs, 1'b0};
                        dvs   <= b_abs;
                        neg_q <= sdiv && (opdata1_i[W-1] ^ opdata2_i[W-1]);
                        neg_r <= sdiv && opdata1_i[W-1];
                        cnt   <= '0;
                        state <= DIVON;
                    end
                end
                DIVON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else if (cnt == 6'd32) begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end else begin
                        dvd <= diff[W] ? dvd << 1 : {diff[W-1:0], dvd[W-1:0], 1'b1};
                        cnt <= cnt + 6'd1;
                    end
                end
                DIVZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and lightly randomised checks of muldiv_unit with a result scoreboard
module tb_muldiv_unit;
    localparam int W = 32;
    logic           clk = 1'b0;
    logic           rst, start_i, annul_i;
    logic [1:0]     op_i;
    logic [W-1:0]   a, b;
    logic           stallreq_o, busy_o, ready_o;
    logic [2*W-1:0] result_o;
    int             checks = 0;
    int             errors = 0;
    logic [63:0]    sb[$];
    logic [63:0]    prev;

    muldiv_unit #(.W(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(a), .opdata2_i(b), .annul_i(annul_i),
        .stallreq_o(stallreq_o), .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for ready, check latency, stall length, result and pulse width
    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int lat);
        int n, st;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a = x; b = y;
        sb.push_back(exp);
        prev = exp;
        #1;
        st = stallreq_o ? 1 : 0;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!ready_o && n < 40) begin
            if (stallreq_o) st++;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " stall_cycles"}, 64'(st), 64'(lat));
        chk({tag, " stall_in_end"}, 64'(stallreq_o), 64'd0);
        if (ready_o && sb.size() > 0) chk({tag, " result"}, result_o, sb.pop_front());
        else chk({tag, " ready"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        chk({tag, " ready_pulse"}, 64'(ready_o), 64'd0);
    endtask

    initial begin
        logic [31:0] x, y;
        logic signed [31:0] sx, sy, q, r;
        longint p;
        int rdy;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset result", result_o, 64'd0);
        chk("reset stall", 64'(stallreq_o), 64'd0);
        rst = 1'b0;

        run("mult", 2'b00, 32'hFFFFFFFD, 32'h5, 64'hFFFFFFFF_FFFFFFF1, 1);
        run("multu", 2'b01, 32'hFFFFFFFD, 32'h5, 64'h00000004_FFFFFFF1, 1);
        run("divu_100_7", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
        run("div_m7_2", 2'b10, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        run("div_intmin", 2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34);
        run("divu_max", 2'b11, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 34);
        run("div_by_zero", 2'b10, 32'd5, 32'd0, 64'd0, 2);
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom_range(1, 32'hFFFF);
            run("divu_rand", 2'b11, x, y, {x % y, x / y}, 34);
            sx = $signed(x); sy = $signed($urandom_range(1, 1000));
            if (i[0]) sy = -sy;
            q = sx / sy; r = sx % sy;
            run("div_rand", 2'b10, sx, sy, {r, q}, 34);
            sy = $signed($urandom);
            p = longint'(sx) * longint'(sy);
            run("mult_rand", 2'b00, sx, sy, p, 1);
        end

        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul busy", 64'(busy_o), 64'd0);
        chk("annul ready", 64'(ready_o), 64'd0);
        chk("annul result", result_o, prev);
        rdy = 0;
        repeat (40) begin @(negedge clk); if (ready_o) rdy++; end
        chk("annul no_pulse", 64'(rdy), 64'd0);

        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 64'(busy_o), 64'd0);
        chk("midrst ready", 64'(ready_o), 64'd0);
        chk("midrst result", result_o, 64'd0);
        chk("midrst stall", 64'(stallreq_o), 64'd0);

        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; a = 32'd6; b = 32'd7;
        sb.push_back(64'd42);
        @(negedge clk);
        chk("b2b first ready", 64'(ready_o), 64'd1);
        if (sb.size() > 0) chk("b2b first result", result_o, sb.pop_front());
        op_i = 2'b01; a = 32'hFFFFFFFF; b = 32'd2;
        sb.push_back(64'h00000001_FFFFFFFE);
        @(negedge clk);
        chk("b2b idle ready", 64'(ready_o), 64'd0);
        chk("b2b idle busy", 64'(busy_o), 64'd0);
        chk("b2b idle stall", 64'(stallreq_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b second ready", 64'(ready_o), 64'd1);
        if (sb.size() > 0) chk("b2b second result", result_o, sb.pop_front());
        @(negedge clk);
        chk("b2b second pulse", 64'(ready_o), 64'd0);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
